// File: rtl/fp_mul_issue.sv
// fp_mul_issue: operand issue FIFO in front of the combinational FP32 multiplier.
// Each operand pair is classified as it is written; pairs whose product is
// fixed by special-case rules carry a bypass flag and value through the FIFO.
// Optional build macro FP_MUL_ISSUE_STATS_EN adds push/bypass counters.
module fp_mul_issue #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_DENORM = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              a,
  output logic [31:0]              b,
  output logic                     bypass,
  output logic [31:0]              bypass_val,
  output logic [$clog2(DEPTH):0]   count
`ifdef FP_MUL_ISSUE_STATS_EN
  ,
  output logic [31:0]              push_cnt,
  output logic [31:0]              bypass_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 97;  // {a, b, bypass, bypass_val}
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   a_reg, b_reg, bypass_val_reg;
  logic          bypass_reg;
  logic          push, pop, head_from_in;
  logic [EW-1:0] in_entry, head_next;

  // Write-side classification of each operand
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, prod_sign;
  logic        in_bypass;
  logic [31:0] in_bypass_val;

  assign a_nan  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'h0);
  assign a_inf  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'h0);
  assign a_zero = (in_a[30:23] == 8'h00) && ((in_a[22:0] == 23'h0) || (FLUSH_DENORM != 0));
  assign b_nan  = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'h0);
  assign b_inf  = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'h0);
  assign b_zero = (in_b[30:23] == 8'h00) && ((in_b[22:0] == 23'h0) || (FLUSH_DENORM != 0));
  assign prod_sign = in_a[31] ^ in_b[31];

  // Special-case product selection in priority order (NaN first)
  always_comb begin
    in_bypass     = 1'b0;
    in_bypass_val = 32'h0;
    if (a_nan || b_nan) begin
      in_bypass     = 1'b1;
      in_bypass_val = QNAN;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      in_bypass     = 1'b1;
      in_bypass_val = QNAN;
    end else if (a_inf || b_inf) begin
      in_bypass     = 1'b1;
      in_bypass_val = {prod_sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      in_bypass     = 1'b1;
      in_bypass_val = {prod_sign, 31'h0};
    end
  end

  assign in_entry  = {in_a, in_b, in_bypass, in_bypass_val};
  assign in_ready  = !reset && (count_reg != FULL);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  // The new head is the incoming pair when nothing older remains after this edge
  assign head_from_in = push && ((count_reg == '0) || (pop && count_reg == CW'(1)));
  assign head_next    = head_from_in ? in_entry : mem[rd_ptr_next];

  // Occupancy update
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage array write port (no reset so it maps onto RAM)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_entry;
  end

  // Pointers, occupancy and registered head outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      a_reg          <= 32'h0;
      b_reg          <= 32'h0;
      bypass_reg     <= 1'b0;
      bypass_val_reg <= 32'h0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // When the FIFO goes empty the last head value is held
      if (count_next != '0) begin
        {a_reg, b_reg, bypass_reg, bypass_val_reg} <= head_next;
      end
    end
  end

  assign a          = a_reg;
  assign b          = b_reg;
  assign bypass     = bypass_reg;
  assign bypass_val = bypass_val_reg;
  assign count      = count_reg;

`ifdef FP_MUL_ISSUE_STATS_EN
  logic [31:0] push_cnt_reg, bypass_cnt_reg;

  // Traffic counters, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_cnt_reg   <= 32'h0;
      bypass_cnt_reg <= 32'h0;
    end else begin
      if (push)              push_cnt_reg   <= push_cnt_reg + 32'd1;
      if (pop && bypass_reg) bypass_cnt_reg <= bypass_cnt_reg + 32'd1;
    end
  end

  assign push_cnt   = push_cnt_reg;
  assign bypass_cnt = bypass_cnt_reg;
`endif

endmodule

// File: tb/tb_fp_mul_issue.sv
// tb_fp_mul_issue: directed checks of fp_mul_issue with hand-computed values.
// Two instances share the stimulus: FLUSH_DENORM=1 (main) and FLUSH_DENORM=0.
`timescale 1ns/1ps
module tb_fp_mul_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, out_valid, bypass;
  logic [31:0] a, b, bypass_val;
  logic [2:0]  count;
  logic        in_ready_f0, out_valid_f0, bypass_f0;
  logic [31:0] a_f0, b_f0, bypass_val_f0;
  logic [2:0]  count_f0;
`ifdef FP_MUL_ISSUE_STATS_EN
  logic [31:0] push_cnt, bypass_cnt, push_cnt_f0, bypass_cnt_f0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_mul_issue #(.DEPTH(4), .FLUSH_DENORM(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .bypass(bypass), .bypass_val(bypass_val), .count(count)
`ifdef FP_MUL_ISSUE_STATS_EN
    , .push_cnt(push_cnt), .bypass_cnt(bypass_cnt)
`endif
  );

  fp_mul_issue #(.DEPTH(4), .FLUSH_DENORM(0)) dut_f0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_f0),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_f0), .out_ready(out_ready),
    .a(a_f0), .b(b_f0), .bypass(bypass_f0), .bypass_val(bypass_val_f0), .count(count_f0)
`ifdef FP_MUL_ISSUE_STATS_EN
    , .push_cnt(push_cnt_f0), .bypass_cnt(bypass_cnt_f0)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // advance one clock and settle 1ns past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // push one pair into an empty FIFO, check the head one cycle later, then pop it
  task automatic single(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic eb, input logic [31:0] ev,
                        input logic eb0, input logic [31:0] ev0);
    in_a = va; in_b = vb; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_val({name, " out_valid"}, 32'(out_valid), 32'd1);
    check_val({name, " a"}, a, va);
    check_val({name, " b"}, b, vb);
    check_val({name, " bypass"}, 32'(bypass), 32'(eb));
    check_val({name, " bypass_val"}, bypass_val, ev);
    check_val({name, " count"}, 32'(count), 32'd1);
    check_val({name, " bypass nf"}, 32'(bypass_f0), 32'(eb0));
    check_val({name, " bypass_val nf"}, bypass_val_f0, ev0);
    step();
    check_val({name, " count after pop"}, 32'(count), 32'd0);
  endtask

  function automatic logic [31:0] pa(input int i);
    return 32'h4000_0000 | 32'(i + 1);
  endfunction
  function automatic logic [31:0] pb(input int i);
    return 32'h3F80_0000 | 32'(i + 1);
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #12;
    check_val("reset in_ready", 32'(in_ready), 32'd0);
    check_val("reset out_valid", 32'(out_valid), 32'd0);
    check_val("reset count", 32'(count), 32'd0);
    check_val("reset a", a, 32'h0);
    check_val("reset bypass_val", bypass_val, 32'h0);
    step();
    reset = 1'b0;
    #1;
    check_val("post reset in_ready", 32'(in_ready), 32'd1);

    // directed single-pair vectors
    single("3x2",       32'h4040_0000, 32'h4000_0000, 1'b0, 32'h0,          1'b0, 32'h0);
    check_val("3x2 a held when empty", a, 32'h4040_0000);
    check_val("3x2 out_valid empty", 32'(out_valid), 32'd0);
    single("nan x 1",   32'h7FC0_0001, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 1'b1, 32'h7FC0_0000);
    single("inf x -0",  32'h7F80_0000, 32'h8000_0000, 1'b1, 32'h7FC0_0000, 1'b1, 32'h7FC0_0000);
    single("-inf x 2",  32'hFF80_0000, 32'h4000_0000, 1'b1, 32'hFF80_0000, 1'b1, 32'hFF80_0000);
    single("den x -2",  32'h0000_0001, 32'hC000_0000, 1'b1, 32'h8000_0000, 1'b0, 32'h0);
    single("0 x nan",   32'h0000_0000, 32'hFF80_0001, 1'b1, 32'h7FC0_0000, 1'b1, 32'h7FC0_0000);
    single("-0 x -0",   32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000);
    single("den x inf", 32'h8000_0010, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b1, 32'hFF80_0000);

    // fill with out_ready low; the fifth pair must wait
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_a = pa(k); in_b = pb(k); in_valid = 1'b1;
      check_val($sformatf("fill in_ready %0d", k), 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    check_val("full count", 32'(count), 32'd4);
    check_val("full a", a, pa(0));
    step();
    check_val("full a stable", a, pa(0));
    check_val("full b stable", b, pb(0));
    check_val("full count stable", 32'(count), 32'd4);
    out_ready = 1'b1;
    step();
    check_val("first pop count", 32'(count), 32'd3);
    check_val("first pop a", a, pa(1));
    check_val("first pop in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check_val("push+pop count", 32'(count), 32'd3);
    for (int k = 2; k < 5; k++) begin
      check_val($sformatf("drain a %0d", k), a, pa(k));
      check_val($sformatf("drain b %0d", k), b, pb(k));
      step();
    end
    check_val("drained count", 32'(count), 32'd0);

    // reset in the middle of operation
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_a = pa(k + 10); in_b = pb(k + 10); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check_val("pre-reset count", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check_val("async reset out_valid", 32'(out_valid), 32'd0);
    check_val("async reset count", 32'(count), 32'd0);
    check_val("async reset a", a, 32'h0);
    check_val("async reset b", b, 32'h0);
    check_val("async reset in_ready", 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    in_a = 32'h4080_0000; in_b = 32'h4000_0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("after reset out_valid", 32'(out_valid), 32'd1);
    check_val("after reset a", a, 32'h4080_0000);
    check_val("after reset count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    check_val("after reset drained", 32'(count), 32'd0);

`ifdef FP_MUL_ISSUE_STATS_EN
    // counters: 10 pushes, three of them special-case
    #2 reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_a = (k == 2 || k == 5 || k == 8) ? 32'h0 : pa(k);
      in_b = pb(k);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check_val("stats push_cnt", push_cnt, 32'd10);
    check_val("stats bypass_cnt", bypass_cnt, 32'd3);
    check_val("stats count", 32'(count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
